// File: rtl/ecc_pkg.sv
// ecc_pkg: shared field/curve constants, point type, FSM encodings and modular helpers
package ecc_pkg;
    localparam int ECC_P  = 11;
    localparam int ECC_A  = 1;
    localparam int ECC_B  = 6;
    localparam int ECC_W  = 9;
    localparam int ECC_KW = 4;

    typedef struct packed {
        logic [ECC_W-1:0] x;
        logic [ECC_W-1:0] y;
        logic             inf;
    } point_t;

    localparam point_t INF_PT = '{x: '0, y: '0, inf: 1'b1};

    typedef enum logic [2:0] {OP_IDLE, OP_CHK, OP_INV, OP_X3, OP_Y3, OP_DONE} op_state_t;
    typedef enum logic [2:0] {D_IDLE, D_DBL, D_ADD, D_NEXT, D_NEG, D_SUB, D_DONE} dec_state_t;

    // Operands are already reduced, so one conditional subtract suffices.
    function automatic logic [ECC_W-1:0] mod_red(input logic [ECC_W:0] s, input logic [ECC_W-1:0] p);
        return (s >= {1'b0, p}) ? ECC_W'(s - {1'b0, p}) : s[ECC_W-1:0];
    endfunction

    function automatic logic [ECC_W-1:0] mod_add(input logic [ECC_W-1:0] a, b, p);
        return mod_red({1'b0, a} + {1'b0, b}, p);
    endfunction

    function automatic logic [ECC_W-1:0] mod_sub(input logic [ECC_W-1:0] a, b, p);
        return mod_red({1'b0, a} + {1'b0, p} - {1'b0, b}, p);
    endfunction

    function automatic logic [ECC_W-1:0] mod_mul(input logic [ECC_W-1:0] a, b, p);
        logic [2*ECC_W-1:0] prod;
        prod = {{ECC_W{1'b0}}, a} * {{ECC_W{1'b0}}, b};
        return ECC_W'(prod % {{ECC_W{1'b0}}, p});
    endfunction

    function automatic logic on_curve(input point_t q);
        logic [ECC_W-1:0] pw, x2, rhs;
        pw  = ECC_W'(ECC_P);
        x2  = mod_mul(q.x, q.x, pw);
        rhs = mod_add(mod_add(mod_mul(x2, q.x, pw), mod_mul(ECC_W'(ECC_A), q.x, pw), pw), ECC_W'(ECC_B), pw);
        return q.inf || (mod_mul(q.y, q.y, pw) == rhs);
    endfunction
endpackage

// File: rtl/ecc_point_op.sv
// ecc_point_op: sequential point add/double with special-case shortcut and trial-search inverse
module ecc_point_op import ecc_pkg::*; #(
    parameter int P = ECC_P,
    parameter int A = ECC_A,
    parameter int W = ECC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [W-1:0] i_a_x,
    input  logic [W-1:0] i_a_y,
    input  logic         i_a_inf,
    input  logic [W-1:0] i_b_x,
    input  logic [W-1:0] i_b_y,
    input  logic         i_b_inf,
    output logic         o_done,
    output logic [W-1:0] o_r_x,
    output logic [W-1:0] o_r_y,
    output logic         o_r_inf
);
    localparam logic [W-1:0] PW    = W'(P);
    localparam logic [W-1:0] AW    = W'(A);
    localparam logic [W-1:0] ONE   = W'(1);
    localparam logic [W-1:0] THREE = W'(3);

    op_state_t    r_state, w_next;
    point_t       r_a, r_b, r_res;
    logic [W-1:0] r_num, r_den, r_t, r_lam, r_x3;
    logic [W-1:0] w_num, w_den, w_lam, w_x3, w_y3;
    logic         w_equal, w_inv_pair, w_special, w_hit;

    assign w_equal    = (r_a.x == r_b.x) && (r_a.y == r_b.y);
    assign w_inv_pair = (r_a.x == r_b.x) && (r_a.y == mod_sub('0, r_b.y, PW));
    assign w_special  = r_a.inf || r_b.inf || w_inv_pair;
    assign w_num      = w_equal ? mod_add(mod_mul(THREE, mod_mul(r_a.x, r_a.x, PW), PW), AW, PW)
                                : mod_sub(r_b.y, r_a.y, PW);
    assign w_den      = w_equal ? mod_add(r_a.y, r_a.y, PW) : mod_sub(r_b.x, r_a.x, PW);
    // The last candidate is taken unconditionally so a bad operand cannot stall the search.
    assign w_hit      = (mod_mul(r_t, r_den, PW) == ONE) || (r_t == PW - ONE);
    assign w_lam      = mod_mul(r_num, r_t, PW);
    assign w_x3       = mod_sub(mod_sub(mod_mul(w_lam, w_lam, PW), r_a.x, PW), r_b.x, PW);
    assign w_y3       = mod_sub(mod_mul(r_lam, mod_sub(r_a.x, r_x3, PW), PW), r_a.y, PW);

    assign o_done  = r_state == OP_DONE;
    assign o_r_x   = r_res.x;
    assign o_r_y   = r_res.y;
    assign o_r_inf = r_res.inf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= OP_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            OP_IDLE: w_next = i_start ? OP_CHK : OP_IDLE;
            OP_CHK:  w_next = w_special ? OP_DONE : OP_INV;
            OP_INV:  w_next = w_hit ? OP_X3 : OP_INV;
            OP_X3:   w_next = OP_Y3;
            OP_Y3:   w_next = OP_DONE;
            default: w_next = OP_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_num <= '0;
            r_den <= '0;
            r_t   <= '0;
            r_lam <= '0;
            r_x3  <= '0;
        end else begin
            case (r_state)
                OP_IDLE: if (i_start) begin
                    r_a <= '{i_a_x, i_a_y, i_a_inf};
                    r_b <= '{i_b_x, i_b_y, i_b_inf};
                end
                OP_CHK: begin
                    r_num <= w_num;
                    r_den <= w_den;
                    r_t   <= ONE;
                    r_res <= r_a.inf ? r_b : (r_b.inf ? r_a : INF_PT);
                end
                OP_INV: if (!w_hit) r_t <= r_t + ONE;
                OP_X3: begin
                    r_lam <= w_lam;
                    r_x3  <= w_x3;
                end
                OP_Y3: r_res <= '{r_x3, w_y3, 1'b0};
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/ecc_point_decrypt.sv
// ecc_point_decrypt: EC-ElGamal decryption M = C2 - d*C1 via MSB-first double-and-add
module ecc_point_decrypt import ecc_pkg::*; #(
    parameter int P  = ECC_P,
    parameter int A  = ECC_A,
    parameter int W  = ECC_W,
    parameter int KW = ECC_KW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  c1_x,
    input  logic [W-1:0]  c1_y,
    input  logic          c1_inf,
    input  logic [W-1:0]  c2_x,
    input  logic [W-1:0]  c2_y,
    input  logic          c2_inf,
    input  logic [KW-1:0] key,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  m_x,
    output logic [W-1:0]  m_y,
    output logic          m_inf
);
    localparam int           IW = $clog2(KW);
    localparam logic [W-1:0] PW = W'(P);

    dec_state_t    r_state, w_next;
    point_t        r_c1, r_c2, r_r, r_m, w_op_a, w_op_b;
    logic [KW-1:0] r_key;
    logic [IW-1:0] r_i;
    logic          r_launch, w_op_done, w_res_inf;
    logic [W-1:0]  w_res_x, w_res_y;

    // DBL: R+R, ADD: R+C1, SUB: C2+R (R already negated)
    assign w_op_a = (r_state == D_SUB) ? r_c2 : r_r;
    assign w_op_b = (r_state == D_ADD) ? r_c1 : r_r;

    assign busy  = (r_state != D_IDLE) && (r_state != D_DONE);
    assign done  = r_state == D_DONE;
    assign m_x   = r_m.x;
    assign m_y   = r_m.y;
    assign m_inf = r_m.inf;

    ecc_point_op #(.P(P), .A(A), .W(W)) u_op (
        .clk     (clk),
        .rst     (rst),
        .i_start (r_launch),
        .i_a_x   (w_op_a.x),
        .i_a_y   (w_op_a.y),
        .i_a_inf (w_op_a.inf),
        .i_b_x   (w_op_b.x),
        .i_b_y   (w_op_b.y),
        .i_b_inf (w_op_b.inf),
        .o_done  (w_op_done),
        .o_r_x   (w_res_x),
        .o_r_y   (w_res_y),
        .o_r_inf (w_res_inf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= D_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            D_IDLE:  w_next = start ? D_DBL : D_IDLE;
            D_DBL:   if (w_op_done) w_next = r_key[r_i] ? D_ADD : D_NEXT;
            D_ADD:   if (w_op_done) w_next = D_NEXT;
            D_NEXT:  w_next = (r_i == '0) ? D_NEG : D_DBL;
            D_NEG:   w_next = D_SUB;
            D_SUB:   if (w_op_done) w_next = D_DONE;
            default: w_next = D_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c1     <= '0;
            r_c2     <= '0;
            r_r      <= '0;
            r_m      <= '0;
            r_key    <= '0;
            r_i      <= '0;
            r_launch <= 1'b0;
        end else begin
            r_launch <= (w_next == D_DBL || w_next == D_ADD || w_next == D_SUB) && (w_next != r_state);
            case (r_state)
                D_IDLE: if (start) begin
                    r_c1  <= '{c1_x, c1_y, c1_inf};
                    r_c2  <= '{c2_x, c2_y, c2_inf};
                    r_key <= key;
                    r_r   <= INF_PT;
                    r_i   <= IW'(KW - 1);
                end
                D_DBL, D_ADD: if (w_op_done) r_r <= '{w_res_x, w_res_y, w_res_inf};
                D_NEXT: if (r_i != '0) r_i <= r_i - IW'(1);
                D_NEG:  r_r.y <= mod_sub('0, r_r.y, PW);
                D_SUB:  if (w_op_done) r_m <= w_res_inf ? INF_PT : '{w_res_x, w_res_y, 1'b0};
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ecc_point_decrypt.sv
// tb_ecc_point_decrypt: directed decryptions on y^2 = x^3 + x + 6 over GF(11), G = (2,7) of order 13
module tb_ecc_point_decrypt;
    localparam int BOUND = (2 * 4 + 1) * (11 + 3) + 4;
    localparam int LIMIT = 400;

    logic       clk = 1'b0;
    logic       rst, start, c1_inf, c2_inf;
    logic [8:0] c1_x, c1_y, c2_x, c2_y, m_x, m_y;
    logic [3:0] key;
    logic       busy, done, m_inf;

    int tests = 0;
    int fails = 0;
    int sb[$];
    // Index k holds kG; index 0 is the point at infinity.
    int mx[13] = '{0, 2, 5, 8, 10, 3, 7, 7, 3, 10, 8, 5, 2};
    int my[13] = '{0, 7, 2, 3, 2, 6, 9, 2, 5, 9, 8, 9, 4};

    ecc_point_decrypt dut (
        .clk(clk), .rst(rst), .start(start),
        .c1_x(c1_x), .c1_y(c1_y), .c1_inf(c1_inf),
        .c2_x(c2_x), .c2_y(c2_y), .c2_inf(c2_inf),
        .key(key), .busy(busy), .done(done),
        .m_x(m_x), .m_y(m_y), .m_inf(m_inf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int k, input int j1, input int j2);
        c1_x   = 9'(mx[j1]);
        c1_y   = 9'(my[j1]);
        c1_inf = (j1 == 0);
        c2_x   = 9'(mx[j2]);
        c2_y   = 9'(my[j2]);
        c2_inf = (j2 == 0);
        key    = 4'(k);
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "/done_seen"}, 32'(done), 1);
    endtask

    task automatic check_result(input string tag, input int cyc);
        int e;
        e = sb.pop_front();
        if (done === 1'b1) begin
            check({tag, "/m_x"}, m_x, mx[e]);
            check({tag, "/m_y"}, m_y, my[e]);
            check({tag, "/m_inf"}, 32'(m_inf), 32'(e == 0));
            check({tag, "/busy_at_done"}, 32'(busy), 0);
            check({tag, "/latency_ok"}, 32'(cyc <= BOUND), 1);
        end
    endtask

    // C1 = j1*G, C2 = j2*G, so M = (j2 - k*j1) mod 13 times G.
    task automatic do_op(input string tag, input int k, input int j1, input int j2);
        int cyc;
        @(negedge clk);
        set_ops(k, j1, j2);
        start = 1'b1;
        sb.push_back((((j2 - k * j1) % 13) + 13) % 13);
        @(negedge clk);
        start = 1'b0;
        check({tag, "/busy"}, 32'(busy), 1);
        wait_done(tag, cyc);
        check_result(tag, cyc);
    endtask

    initial begin
        int cyc;
        int seen;
        rst   = 1'b1;
        start = 1'b0;
        set_ops(0, 0, 0);
        repeat (2) @(negedge clk);
        check("reset/busy", 32'(busy), 0);
        check("reset/done", 32'(done), 0);
        check("reset/m_x", m_x, 0);
        check("reset/m_y", m_y, 0);
        check("reset/m_inf", 32'(m_inf), 0);
        rst = 1'b0;

        do_op("key0", 0, 1, 2);
        do_op("key1", 1, 1, 3);
        do_op("key7", 7, 1, 10);
        do_op("key5_inf", 5, 1, 5);
        do_op("key13", 13, 1, 6);
        do_op("k3_c1_2G", 3, 2, 9);
        do_op("k15", 15, 1, 4);
        do_op("c2_inf", 6, 5, 0);
        do_op("c1_inf", 9, 0, 6);
        do_op("k2_c1_12G", 2, 12, 1);
        do_op("k11_c1_3G", 11, 3, 7);

        // Re-pulsing start mid-operation with other operands must not disturb the first job.
        @(negedge clk);
        set_ops(1, 1, 3);
        start = 1'b1;
        sb.push_back(2);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        set_ops(7, 4, 10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("repulse", cyc);
        check_result("repulse", cyc + 4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_on_done/busy", 32'(busy), 0);
        check("start_on_done/done", 32'(done), 0);
        repeat (3) @(negedge clk);
        check("hold/m_x", m_x, 5);
        check("hold/m_y", m_y, 2);
        check("idle/busy", 32'(busy), 0);

        // Asynchronous reset during the first doubling aborts the job.
        set_ops(7, 1, 10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_rst/busy", 32'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst/busy", 32'(busy), 0);
        check("rst/done", 32'(done), 0);
        check("rst/m_x", m_x, 0);
        check("rst/m_y", m_y, 0);
        check("rst/m_inf", 32'(m_inf), 0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (150) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        check("rst/no_done", seen, 0);

        do_op("after_rst", 1, 1, 3);

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ecc_point_decrypt.md
# ecc_point_decrypt

Sequential EC-ElGamal decryptor over the prime field GF(P) on the curve y² = x³ + A·x + B (default P = 11, A = 1, B = 6). It takes a ciphertext pair (C1, C2) and a private key d, and recovers the message point M = C2 − d·C1. It uses double-and-add scalar multiplication followed by point subtraction. It is the receive-side counterpart of the combinational point adder and shares its field and curve constants.

## Interface
Parameters:
- P, 11: field prime; all coordinates are in [0, P−1].
- A, 1: curve coefficient a, used only in the doubling slope.
- W, 9: coordinate width in bits, unsigned.
- KW, 4: private-key width in bits.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request pulse; sampled only while busy=0.
- c1_x, c1_y  in  W  C1 coordinates.
- c1_inf  in  1  C1 is the point at infinity.
- c2_x, c2_y  in  W  C2 coordinates.
- c2_inf  in  1  C2 is the point at infinity.
- key  in  KW  private key d, unsigned.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; M is valid on this cycle.
- m_x, m_y  out  W  result coordinates; forced to 0 when m_inf=1.
- m_inf  out  1  result is the point at infinity.

## Operation
Top-level FSM:
- IDLE
  - On start=1, latch all inputs, set R = inf and i = KW−1, then go to DBL.
  - start while busy is ignored; the latched inputs are not disturbed.
- DBL: R ← 2R. Then go to ADD if key[i]=1, else go to NEXT.
- ADD: R ← R + C1, then go to NEXT.
- NEXT: if i=0, go to NEG; else decrement i and go to DBL.
- NEG: R ← −R, i.e. y ← (P − y) mod P. Infinity stays infinity.
- SUB: R ← C2 + R, then go to DONE.
- DONE: register M = R, pulse done, clear busy, return to IDLE.

Point-op rules, applied in priority order:
- Either operand is inf → result is the other operand.
- x1 = x2 and y1 = (P − y2) mod P → result is inf. This covers doubling of a point with y = 0.
- Operands are equal → slope λ = (3x² + A)·(2y)⁻¹.
- Otherwise → slope λ = (y2 − y1)·(x2 − x1)⁻¹.
- x3 = (λ² − x1 − x2) mod P; y3 = (λ·(x1 − x3) − y1) mod P.
- Differences are formed as (a + P − b) mod P, so no signed intermediates exist.
- Products are 2W bits wide before reduction; every stored value is in [0, P−1].

Inverse:
- Sequential trial search: t = 1, 2, … until (t·den) mod P = 1, one candidate per cycle.
- den is nonzero whenever this path is reached.

## Timing
- Reset values: busy=0, done=0, m_x=0, m_y=0, m_inf=0, FSMs in IDLE.
- Reset asserted mid-operation aborts immediately. No done is produced, and outputs return to their reset values.
- Point-op latency:
  - Special case (either operand inf, or inverse-pair operands): 2 cycles from op start to op done.
  - General case: 4 + t cycles, where t = den⁻¹ ∈ [1, P−1].
- Whole-operation bound: done arrives at most (2·KW + 1)·(P + 3) + 4 cycles after the accepted start.
- m_* hold their value from done until the next done or reset.
- start on the same cycle as done is ignored. start is accepted on the following cycle, once in IDLE.

## Structure
- Shared package ecc_pkg:
  - constants P, A, B, W, KW;
  - point struct {x, y, inf};
  - functions mod_add, mod_sub, mod_mul.
- The point adder uses the same package.
- One sub-module, ecc_point_op:
  - start/done handshake;
  - operands a and b, result point;
  - contains the special-case check, the inverse search counter and the two-cycle x3/y3 computation.
- The top level instantiates it once and reuses it for every DBL, ADD and SUB step.

## Test plan
Curve defaults: G = (2,7), group order 13.
- key=0, C1=(2,7), C2=(5,2) → M=(5,2), m_inf=0.
- key=1, C1=(2,7), C2=(8,3) → M=(5,2).
- key=7, C1=(2,7), C2=(8,8) → M=(8,3). done must arrive within the latency bound.
- key=5, C1=(2,7), C2=(3,6) → m_inf=1, m_x=0, m_y=0.
- key=13, C1=(2,7), C2=(7,9) → M=(7,9). 13G = inf inside the loop.
- Robustness:
  - start re-pulsed while busy with different operands → first result is unchanged.
  - rst asserted mid-DBL → busy=0 and done=0 on the next edge.
  - A fresh start with key=1, C1=(2,7), C2=(8,3) → M=(5,2).
